// File: rtl/hazard_controller.sv
// hazard_controller
// Stall / flush / freeze decisions for the 5-stage RISC-V pipeline.
// Handles load-use hazards, taken-branch flushes resolved in EX and
// multi-cycle data-memory waits with a timeout that halts the pipeline.
// Control outputs are Mealy (state + current inputs) so they act in the
// same cycle. An asserted reset overrides them with the safe
// "hold PC, flush IF/ID, bubble ID/EX" pattern.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             if_id_rs1,
  input  logic [4:0]             if_id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   id_ex_mem_read,
  input  logic [4:0]             id_ex_rd,
  input  logic                   ex_branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   pipe_freeze,
  output logic                   halted,
  output logic [1:0]             state_out,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);

  // Width of the memory-wait counter; must be able to hold MEM_TIMEOUT itself.
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]      WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]      WAIT_ONE   = WAIT_W'(1);
  localparam logic [WAIT_W-1:0]      WAIT_ZERO  = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_t;

  // Load-use: EX holds a load whose non-x0 destination is read by ID.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic       uses_rs1,
    input logic [4:0] rs1,
    input logic       uses_rs2,
    input logic [4:0] rs2
  );
    logic hit_rs1;
    logic hit_rs2;
    hit_rs1 = uses_rs1 && (rs1 == rd);
    hit_rs2 = uses_rs2 && (rs2 == rd);
    return mem_read && (rd != 5'd0) && (hit_rs1 || hit_rs2);
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] cnt,
    input logic                   en
  );
    logic [COUNT_WIDTH-1:0] res;
    if (en && (cnt != CNT_MAX)) begin
      res = cnt + CNT_ONE;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  state_t              state_r;
  state_t              next_state_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [WAIT_W-1:0]   next_wait_cnt_s;
  logic                halted_r;
  logic [COUNT_WIDTH-1:0] stall_count_r;
  logic [COUNT_WIDTH-1:0] flush_count_r;

  logic load_use_s;
  logic mem_wait_s;

  // Decisions of the normal (non-waiting) rules: branch, load-use, advance.
  logic adv_pc_write_s;
  logic adv_if_id_write_s;
  logic adv_if_id_flush_s;
  logic adv_id_ex_bubble_s;

  // Decoded outputs before the reset override.
  logic dec_pc_write_s;
  logic dec_if_id_write_s;
  logic dec_if_id_flush_s;
  logic dec_id_ex_bubble_s;
  logic dec_pipe_freeze_s;
  logic stall_inc_s;
  logic flush_inc_s;

  assign load_use_s = load_use_hit(id_ex_mem_read, id_ex_rd,
                                   id_uses_rs1, if_id_rs1,
                                   id_uses_rs2, if_id_rs2);
  assign mem_wait_s = mem_req && !mem_ready;

  // Branch squash beats load-use because the stalled ID instruction is discarded anyway.
  always_comb begin
    adv_pc_write_s     = 1'b1;
    adv_if_id_write_s  = 1'b1;
    adv_if_id_flush_s  = 1'b0;
    adv_id_ex_bubble_s = 1'b0;
    if (ex_branch_taken) begin
      adv_pc_write_s     = 1'b1;
      adv_if_id_write_s  = 1'b1;
      adv_if_id_flush_s  = 1'b1;
      adv_id_ex_bubble_s = 1'b1;
    end else if (load_use_s) begin
      adv_pc_write_s     = 1'b0;
      adv_if_id_write_s  = 1'b0;
      adv_if_id_flush_s  = 1'b0;
      adv_id_ex_bubble_s = 1'b1;
    end else begin
      adv_pc_write_s     = 1'b1;
      adv_if_id_write_s  = 1'b1;
      adv_if_id_flush_s  = 1'b0;
      adv_id_ex_bubble_s = 1'b0;
    end
  end

  // Next-state logic and state-dependent output decode.
  always_comb begin
    next_state_s       = state_r;
    next_wait_cnt_s    = wait_cnt_r;
    dec_pc_write_s     = adv_pc_write_s;
    dec_if_id_write_s  = adv_if_id_write_s;
    dec_if_id_flush_s  = adv_if_id_flush_s;
    dec_id_ex_bubble_s = adv_id_ex_bubble_s;
    dec_pipe_freeze_s  = 1'b0;
    flush_inc_s        = 1'b0;
    stall_inc_s        = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_wait_s) begin
          // Freeze everything; a pending branch is held and re-applied on completion.
          dec_pc_write_s     = 1'b0;
          dec_if_id_write_s  = 1'b0;
          dec_if_id_flush_s  = 1'b0;
          dec_id_ex_bubble_s = 1'b0;
          dec_pipe_freeze_s  = 1'b1;
          next_state_s       = ST_MEM_WAIT;
          next_wait_cnt_s    = WAIT_ONE;
        end else begin
          flush_inc_s = ex_branch_taken;
        end
        stall_inc_s = !dec_pc_write_s;
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          dec_pc_write_s     = 1'b0;
          dec_if_id_write_s  = 1'b0;
          dec_if_id_flush_s  = 1'b0;
          dec_id_ex_bubble_s = 1'b0;
          dec_pipe_freeze_s  = 1'b1;
          if (wait_cnt_r == WAIT_LIMIT) begin
            next_state_s = ST_HALT;
          end else begin
            next_wait_cnt_s = wait_cnt_r + WAIT_ONE;
          end
        end else begin
          flush_inc_s     = ex_branch_taken;
          next_state_s    = ST_RUN;
          next_wait_cnt_s = WAIT_ZERO;
        end
        stall_inc_s = !dec_pc_write_s;
      end
      ST_HALT: begin
        dec_pc_write_s     = 1'b0;
        dec_if_id_write_s  = 1'b0;
        dec_if_id_flush_s  = 1'b0;
        dec_id_ex_bubble_s = 1'b1;
        dec_pipe_freeze_s  = 1'b1;
        next_state_s       = ST_HALT;
      end
      default: begin
        // Corrupted state encoding: stop the pipeline the same way a timeout does.
        dec_pc_write_s     = 1'b0;
        dec_if_id_write_s  = 1'b0;
        dec_if_id_flush_s  = 1'b0;
        dec_id_ex_bubble_s = 1'b1;
        dec_pipe_freeze_s  = 1'b1;
        next_state_s       = ST_HALT;
      end
    endcase
  end

  // State, wait counter and sticky halt flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= WAIT_ZERO;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= next_wait_cnt_s;
      if (next_state_s == ST_HALT) begin
        halted_r <= 1'b1;
      end else begin
        halted_r <= halted_r;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count_r <= CNT_ZERO;
      flush_count_r <= CNT_ZERO;
    end else begin
      stall_count_r <= sat_inc(stall_count_r, stall_inc_s);
      flush_count_r <= sat_inc(flush_count_r, flush_inc_s);
    end
  end

  // Reset overrides the Mealy outputs with the safe hold/flush/bubble pattern.
  always_comb begin
    pc_write     = dec_pc_write_s;
    if_id_write  = dec_if_id_write_s;
    if_id_flush  = dec_if_id_flush_s;
    id_ex_bubble = dec_id_ex_bubble_s;
    pipe_freeze  = dec_pipe_freeze_s;
    halted       = halted_r;
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      pipe_freeze  = 1'b0;
      halted       = 1'b0;
    end else begin
      halted = halted_r;
    end
  end

  assign state_out   = state_r;
  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
// Directed table vectors for the single-cycle decisions plus hand-written
// sequences for memory wait, timeout halt, async reset and saturation.
module tb_hazard_controller;

  localparam int CW = 3;

  logic          clock;
  logic          reset;
  logic [4:0]    if_id_rs1;
  logic [4:0]    if_id_rs2;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic          id_ex_mem_read;
  logic [4:0]    id_ex_rd;
  logic          ex_branch_taken;
  logic          mem_req;
  logic          mem_ready;
  logic          pc_write;
  logic          if_id_write;
  logic          if_id_flush;
  logic          id_ex_bubble;
  logic          pipe_freeze;
  logic          halted;
  logic [1:0]    state_out;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  int checks;
  int failures;

  hazard_controller #(.MEM_TIMEOUT(4), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_freeze(pipe_freeze), .halted(halted), .state_out(state_out),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
  localparam logic [4:0] O_RUN    = 5'b11000;
  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_FLUSH  = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_RESET  = 5'b00110;
  localparam logic [4:0] O_HALT   = 5'b00011;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [4:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic mr, input logic [4:0] rd,
                       input logic br, input logic req, input logic rdy);
    if_id_rs1 = rs1; if_id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_ex_mem_read = mr; id_ex_rd = rd; ex_branch_taken = br;
    mem_req = req; mem_ready = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full reset pulse, entered and left at a falling edge.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    idle();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    idle();

    vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[1] = '{5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_STALL};
    vecs[2] = '{5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[4] = '{5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[5] = '{5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_STALL};
    vecs[6] = '{5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, O_FLUSH};
    vecs[7] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_FLUSH};
    vecs[8] = '{5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, O_RUN};
    vecs[9] = '{5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, O_RUN};

    // Reset values, held while reset is low.
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_outs", 32'(outs()), 32'(O_RESET));
    chk("reset_state", 32'(state_out), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_stall_cnt", 32'(stall_count), 32'd0);
    chk("reset_flush_cnt", 32'(flush_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Table: single-cycle decisions from RUN.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].mr,
            vecs[i].rd, vecs[i].br, vecs[i].req, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_state", i), 32'(state_out), 32'd0);
    end
    @(negedge clock);
    idle();
    chk("table_stall_cnt", 32'(stall_count), 32'd2);
    chk("table_flush_cnt", 32'(flush_count), 32'd2);

    // Load-use then bubbled follow-up cycle.
    do_reset();
    drive(5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_stall", 32'(outs()), 32'(O_STALL));
    @(negedge clock);
    drive(5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_resume", 32'(outs()), 32'(O_RUN));
    @(negedge clock);
    idle();
    chk("lu_stall_cnt", 32'(stall_count), 32'd1);

    // Branch together with load-use: flush only.
    do_reset();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    chk("br_lu_outs", 32'(outs()), 32'(O_FLUSH));
    @(negedge clock);
    idle();
    chk("br_lu_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_lu_stall_cnt", 32'(stall_count), 32'd0);

    // Memory wait, ready on the 3rd cycle.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("mw_c1_outs", 32'(outs()), 32'(O_FREEZE));
    @(negedge clock);
    #1;
    chk("mw_c2_state", 32'(state_out), 32'd1);
    chk("mw_c2_outs", 32'(outs()), 32'(O_FREEZE));
    @(negedge clock);
    mem_ready = 1'b1;
    #1;
    chk("mw_c3_outs", 32'(outs()), 32'(O_RUN));
    @(negedge clock);
    idle();
    #1;
    chk("mw_done_state", 32'(state_out), 32'd0);
    chk("mw_stall_cnt", 32'(stall_count), 32'd2);

    // Branch held by a memory wait is applied when ready arrives.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("mwbr_c1_outs", 32'(outs()), 32'(O_FREEZE));
    @(negedge clock);
    mem_ready = 1'b1;
    #1;
    chk("mwbr_c2_outs", 32'(outs()), 32'(O_FLUSH));
    @(negedge clock);
    idle();
    chk("mwbr_flush_cnt", 32'(flush_count), 32'd1);
    chk("mwbr_stall_cnt", 32'(stall_count), 32'd1);

    // Reset mid-MEM_WAIT with wait_cnt=3.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    #1;
    chk("mid_state", 32'(state_out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outs()), 32'(O_RESET));
    chk("mid_rst_state", 32'(state_out), 32'd0);
    chk("mid_rst_stall_cnt", 32'(stall_count), 32'd0);
    @(negedge clock);
    idle();
    reset = 1'b1;
    #1;
    chk("mid_rel_outs", 32'(outs()), 32'(O_RUN));
    chk("mid_rel_state", 32'(state_out), 32'd0);

    // Timeout: ready never rises.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("to_c%0d_outs", c), 32'(outs()), 32'(O_FREEZE));
      chk($sformatf("to_c%0d_halted", c), 32'(halted), 32'd0);
      @(negedge clock);
    end
    #1;
    chk("to_state", 32'(state_out), 32'd2);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_outs", 32'(outs()), 32'(O_HALT));
    chk("to_stall_cnt", 32'(stall_count), 32'd5);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clock);
    #1;
    chk("to_hold_state", 32'(state_out), 32'd2);
    chk("to_hold_halted", 32'(halted), 32'd1);
    chk("to_hold_stall_cnt", 32'(stall_count), 32'd5);
    chk("to_hold_flush_cnt", 32'(flush_count), 32'd0);
    reset = 1'b0;
    #1;
    chk("to_rst_outs", 32'(outs()), 32'(O_RESET));
    chk("to_rst_halted", 32'(halted), 32'd0);
    chk("to_rst_state", 32'(state_out), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Saturation of the 3-bit stall counter over 9 load-use stalls.
    do_reset();
    for (int s = 1; s <= 9; s++) begin
      drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      idle();
      @(negedge clock);
      if (s == 7) chk("sat_at7", 32'(stall_count), 32'd7);
    end
    chk("sat_final", 32'(stall_count), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
